shreg_sequencer: RTL and testbench

- Command-driven controller for the 8-bit universal shift register (HOLD / SHIFT left / PARALLEL LOAD / SHIFT right).
- Accepts one command at a time over a valid/ready handshake and drives the register's mode, enable, parallel data and serial-in lines for the required number of cycles.
- Captures the bits shifted out of the register and pulses done when the command completes.
- Sits between the top-level command decode (pins / host logic) and the register instance.

---
 rtl/shreg_sequencer.sv | 102 ++++++++++
 tb/tb_shreg_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shreg_sequencer.sv
// shreg_sequencer: command sequencer for a universal shift register (load/shift/capture); SHREG_ROTATE_EN adds cmd_rotate
module shreg_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
`ifdef SHREG_ROTATE_EN
  input  logic             cmd_rotate,
`endif
  input  logic [WIDTH-1:0] reg_q,
  output logic [1:0]       reg_ctrl,
  output logic             reg_en,
  output logic [WIDTH-1:0] reg_d,
  output logic             reg_sin,
  output logic [WIDTH-1:0] out_bits,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cl;
  logic [1:0]       op_q, op_d;
  logic             dir_q, dir_d, fill_q, fill_d, rot_q, rot_d, act, accept, sin_v;
  logic [WIDTH-1:0] data_q, data_d, out_q, out_d;
  assign act      = ~RESET;
  assign accept   = cmd_valid & cmd_ready;
  assign cnt_cl   = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;
  assign out_bits = out_q;
  // state, counter, latched command and captured bits
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      rot_q   <= 1'b0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      rot_q   <= rot_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end
  // next state: latch on accept, step the shift counter and capture the outgoing bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    rot_d   = rot_q;
    data_d  = data_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = cmd_op;
        dir_d   = cmd_dir;
        fill_d  = cmd_fill;
        data_d  = cmd_data;
        cnt_d   = cnt_cl;
        out_d   = '0;
`ifdef SHREG_ROTATE_EN
        rot_d   = cmd_rotate;
`endif
        state_d = !cmd_op[0] ? LOAD : (cmd_op == 2'b01 && cnt_cl != '0) ? SHIFT : DONE;
      end
      LOAD: state_d = (op_q == 2'b10 && cnt_q != '0) ? SHIFT : DONE;
      SHIFT: begin
        out_d   = dir_q ? {reg_q[0], out_q[WIDTH-1:1]} : {out_q[WIDTH-2:0], reg_q[WIDTH-1]};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Moore outputs, all forced low while RESET is held
  always_comb begin
    sin_v     = rot_q ? (dir_q ? reg_q[0] : reg_q[WIDTH-1]) : fill_q;
    cmd_ready = act && state_q == IDLE;
    busy      = act && state_q != IDLE;
    done      = act && state_q == DONE;
    reg_en    = act && (state_q == LOAD || state_q == SHIFT);
    reg_ctrl  = !act ? 2'b00 : state_q == LOAD ? 2'b10 : state_q == SHIFT ? {dir_q, 1'b1} : 2'b00;
    reg_d     = (act && state_q == LOAD) ? data_q : '0;
    reg_sin   = act & sin_v;
  end
endmodule

// File: tb/tb_shreg_sequencer.sv
// tb_shreg_sequencer: randomized and directed checks of shreg_sequencer driving a behavioural shift register
module tb_shreg_sequencer;
  logic       CLOCK = 0, RESET = 1, cmd_valid = 0, cmd_dir = 0, cmd_fill = 0;
  logic [1:0] cmd_op = 0;
  logic [3:0] cmd_count = 0;
  logic [7:0] cmd_data = 0, sr = 0, m_reg = 0;
`ifdef SHREG_ROTATE_EN
  logic       cmd_rotate = 0;
`endif
  logic       cmd_ready, reg_en, reg_sin, busy, done;
  logic [1:0] reg_ctrl;
  logic [7:0] reg_d, out_bits;
  int checks = 0, errors = 0;
  int lat, en_cnt, sh_cnt, bad;
  bit tmo;

  shreg_sequencer dut (
    .CLOCK(CLOCK), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .cmd_data(cmd_data),
`ifdef SHREG_ROTATE_EN
    .cmd_rotate(cmd_rotate),
`endif
    .reg_q(sr), .reg_ctrl(reg_ctrl), .reg_en(reg_en), .reg_d(reg_d), .reg_sin(reg_sin),
    .out_bits(out_bits), .busy(busy), .done(done)
  );

  always #5 CLOCK = ~CLOCK;

  // universal shift register fixture: 00 hold, 01 left, 10 load, 11 right
  always @(posedge CLOCK)
    if (reg_en)
      sr <= reg_ctrl == 2'b10 ? reg_d : reg_ctrl == 2'b01 ? {sr[6:0], reg_sin} :
            reg_ctrl == 2'b11 ? {reg_sin, sr[7:1]} : sr;

  // expected result of one command computed from its arithmetic meaning
  function automatic void model(input logic [1:0] op, input logic dir, input logic [3:0] cnt,
                                input logic fill, input logic [7:0] data, input logic rot,
                                input logic [7:0] r0, output logic [7:0] r1, output logic [7:0] o,
                                output int l, output int en, output int sh);
    int n;
    logic ld, s;
    logic [15:0] f;
    logic [7:0] v;
    n  = cnt > 8 ? 8 : int'(cnt);
    ld = (op == 2'd0 || op == 2'd2);
    s  = (op == 2'd1 || op == 2'd2) && n != 0;
    v  = ld ? data : r0;
    o  = 8'h00;
    r1 = v;
    if (s) begin
      if (!dir) begin
        f  = {8'h00, v} << n;
        o  = f[15:8];
        r1 = f[7:0] | (rot ? f[15:8] : fill ? 8'((1 << n) - 1) : 8'h00);
      end else begin
        f  = {v, 8'h00} >> n;
        o  = f[7:0];
        r1 = f[15:8] | (rot ? f[7:0] : fill ? ~(8'hFF >> n) : 8'h00);
      end
    end
    sh = s ? n : 0;
    en = int'(ld) + sh;
    l  = en + 1;
  endfunction

  // issue one command from a negedge and observe it until the done cycle
  task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [3:0] cnt,
                         input logic fill, input logic [7:0] data, input logic rot);
    int k;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge CLOCK); k++; end
    cmd_op = op; cmd_dir = dir; cmd_count = cnt; cmd_fill = fill; cmd_data = data;
`ifdef SHREG_ROTATE_EN
    cmd_rotate = rot;
`else
    if (rot) $display("note: rotate requested in a build without rotate");
`endif
    cmd_valid = 1;
    @(posedge CLOCK);
    #1 cmd_valid = 0;
    lat = 1; en_cnt = 0; sh_cnt = 0; bad = 0; tmo = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK);
      if (done) begin tmo = 0; break; end
      en_cnt += int'(reg_en);
      if (reg_en && reg_ctrl == {dir, 1'b1}) sh_cnt++;
      if (!busy || cmd_ready || (reg_ctrl != 2'b10 && reg_d !== 8'h00)) bad++;
      @(posedge CLOCK);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    checks++;
    if ({reg_ctrl, reg_en, reg_d, reg_sin, busy, done, cmd_ready, out_bits} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ctrl=%b en=%b d=%h sin=%b busy=%b done=%b ready=%b out=%h want all zero",
               reg_ctrl, reg_en, reg_d, reg_sin, busy, done, cmd_ready, out_bits);
    end
    RESET = 0;
    @(negedge CLOCK);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_load_shift_left();
    run_cmd(2'b10, 1'b0, 4'd3, 1'b0, 8'hA5, 1'b0);
    checks++;
    if (lat != 5 || en_cnt != 4 || sh_cnt != 3 || bad != 0 || tmo) begin
      errors++;
      $display("FAIL left_timing: got lat=%0d en=%0d sh=%0d bad=%0d tmo=%0d want 5 4 3 0 0", lat, en_cnt, sh_cnt, bad, tmo);
    end
    checks++;
    if (sr !== 8'h28 || out_bits !== 8'h05) begin
      errors++;
      $display("FAIL left_result: got reg=%h out=%h want reg=28 out=05", sr, out_bits);
    end
    m_reg = 8'h28;
  endtask

  task automatic test_load_shift_right();
    run_cmd(2'b10, 1'b1, 4'd4, 1'b0, 8'h0F, 1'b0);
    checks++;
    if (lat != 6 || en_cnt != 5 || sh_cnt != 4 || bad != 0 || tmo) begin
      errors++;
      $display("FAIL right_timing: got lat=%0d en=%0d sh=%0d bad=%0d tmo=%0d want 6 5 4 0 0", lat, en_cnt, sh_cnt, bad, tmo);
    end
    checks++;
    if (sr !== 8'h00 || out_bits !== 8'hF0) begin
      errors++;
      $display("FAIL right_result: got reg=%h out=%h want reg=00 out=f0", sr, out_bits);
    end
    m_reg = 8'h00;
  endtask

  task automatic test_noop();
    run_cmd(2'b10, 1'b0, 4'd0, 1'b0, 8'h3C, 1'b0);
    checks++;
    if (lat != 2 || en_cnt != 1 || sr !== 8'h3C || out_bits !== 8'h00) begin
      errors++;
      $display("FAIL load_only: got lat=%0d en=%0d reg=%h out=%h want 2 1 3c 00", lat, en_cnt, sr, out_bits);
    end
    run_cmd(2'b01, 1'b0, 4'd0, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (lat != 1 || en_cnt != 0 || sr !== 8'h3C || out_bits !== 8'h00) begin
      errors++;
      $display("FAIL shift_zero: got lat=%0d en=%0d reg=%h out=%h want 1 0 3c 00", lat, en_cnt, sr, out_bits);
    end
    run_cmd(2'b11, 1'b1, 4'd5, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (lat != 1 || en_cnt != 0 || sr !== 8'h3C || out_bits !== 8'h00) begin
      errors++;
      $display("FAIL reserved_op: got lat=%0d en=%0d reg=%h out=%h want 1 0 3c 00", lat, en_cnt, sr, out_bits);
    end
    m_reg = 8'h3C;
  endtask

  task automatic test_clamp();
    run_cmd(2'b10, 1'b0, 4'd15, 1'b1, 8'h81, 1'b0);
    checks++;
    if (lat != 10 || en_cnt != 9 || sh_cnt != 8 || bad != 0 || tmo) begin
      errors++;
      $display("FAIL clamp_timing: got lat=%0d en=%0d sh=%0d bad=%0d tmo=%0d want 10 9 8 0 0", lat, en_cnt, sh_cnt, bad, tmo);
    end
    checks++;
    if (sr !== 8'hFF || out_bits !== 8'h81) begin
      errors++;
      $display("FAIL clamp_result: got reg=%h out=%h want reg=ff out=81", sr, out_bits);
    end
    m_reg = 8'hFF;
  endtask

  task automatic test_reset_mid();
    int seen_done;
    logic [7:0] d;
    seen_done = 0;
    while (!cmd_ready) @(negedge CLOCK);
    cmd_op = 2'b10; cmd_dir = 0; cmd_count = 4'd5; cmd_fill = 1; cmd_data = 8'hC3; cmd_valid = 1;
    @(posedge CLOCK);
    #1 cmd_valid = 0;
    repeat (3) begin @(negedge CLOCK); seen_done += int'(done); end
    RESET = 1;
    @(negedge CLOCK);
    seen_done += int'(done);
    checks++;
    if (busy !== 1'b0 || reg_en !== 1'b0 || out_bits !== 8'h00 || cmd_ready !== 1'b0 || reg_ctrl !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b en=%b out=%h ready=%b ctrl=%b want 0 0 00 0 00", busy, reg_en, out_bits, cmd_ready, reg_ctrl);
    end
    RESET = 0;
    @(negedge CLOCK);
    seen_done += int'(done);
    checks++;
    if (cmd_ready !== 1'b1 || seen_done != 0) begin
      errors++;
      $display("FAIL mid_reset_release: got ready=%b done_pulses=%0d want ready=1 done_pulses=0", cmd_ready, seen_done);
    end
    d = 8'($urandom);
    run_cmd(2'b00, 1'b0, 4'd3, 1'b0, d, 1'b0);
    checks++;
    if (sr !== d || lat != 2) begin
      errors++;
      $display("FAIL reload_after_reset: got reg=%h lat=%0d want reg=%h lat=2", sr, lat, d);
    end
    m_reg = d;
  endtask

  task automatic test_back_to_back();
    int pulses, first;
    pulses = 0;
    while (!cmd_ready) @(negedge CLOCK);
    cmd_op = 2'b11; cmd_valid = 1;
    @(negedge CLOCK);
    first = int'(done);
    pulses = first;
    repeat (7) begin @(negedge CLOCK); pulses += int'(done); end
    cmd_valid = 0;
    checks++;
    if (pulses != 4 || first != 1 || sr !== m_reg) begin
      errors++;
      $display("FAIL back_to_back: got pulses=%0d first=%0d reg=%h want 4 1 %h", pulses, first, sr, m_reg);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [3:0] cnt;
    logic [7:0] data, er, eo;
    logic dir, fill, rot;
    int el, een, esh;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3)); dir = 1'($urandom); cnt = 4'($urandom);
      fill = 1'($urandom); data = 8'($urandom);
`ifdef SHREG_ROTATE_EN
      rot = 1'($urandom);
`else
      rot = 1'b0;
`endif
      model(op, dir, cnt, fill, data, rot, m_reg, er, eo, el, een, esh);
      run_cmd(op, dir, cnt, fill, data, rot);
      checks++;
      if (sr !== er || out_bits !== eo) begin
        errors++;
        $display("FAIL rand_result[%0d] op=%0d dir=%0d cnt=%0d fill=%0d data=%h: got reg=%h out=%h want reg=%h out=%h",
                 i, op, dir, cnt, fill, data, sr, out_bits, er, eo);
      end
      checks++;
      if (lat != el || en_cnt != een || sh_cnt != esh || bad != 0 || tmo) begin
        errors++;
        $display("FAIL rand_timing[%0d]: got lat=%0d en=%0d sh=%0d bad=%0d tmo=%0d want %0d %0d %0d 0 0",
                 i, lat, en_cnt, sh_cnt, bad, tmo, el, een, esh);
      end
      m_reg = er;
    end
  endtask

`ifdef SHREG_ROTATE_EN
  task automatic test_rotate();
    run_cmd(2'b10, 1'b0, 4'd1, 1'b0, 8'h81, 1'b1);
    checks++;
    if (sr !== 8'h03 || out_bits !== 8'h01) begin
      errors++;
      $display("FAIL rotate: got reg=%h out=%h want reg=03 out=01", sr, out_bits);
    end
    m_reg = 8'h03;
  endtask
`endif

  initial begin
    test_reset();
    test_load_shift_left();
    test_load_shift_right();
    test_noop();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
`ifdef SHREG_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
